// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction fetch sequencer.
//
// Drives the instruction ROM address (InstAddress) through a small
// IDLE / RUN / HALT state machine. In RUN the PC advances once per edge,
// with priority HaltReq > Stall > BranchEn > sequential increment.
// Relative branches add a sign-extended Target to the PC, modulo 2**IW.
//
// Optional feature: define FETCH_CYCLE_COUNT_EN to build the RUN-cycle
// counter behind CycleCount. Without it CycleCount is tied to 0.
//
// Ports:
//   Clk         in   clock, rising edge
//   Reset_n     in   synchronous active-low reset
//   Start       in   begin a run (accepted only in IDLE)
//   StartAddr   in   [IW] first address of the run
//   Stall       in   hold PC this cycle
//   BranchEn    in   take a branch this cycle
//   BranchRel   in   1: Target is a signed offset, 0: absolute address
//   Target      in   [IW] branch target / offset
//   HaltReq     in   current instruction is a halt
//   InstAddress out  [IW] registered PC
//   Running     out  high while in RUN
//   Done        out  one-cycle pulse in HALT
//   CycleCount  out  [CW] RUN-cycle count (0 unless FETCH_CYCLE_COUNT_EN)
module fetch_ctrl #(
    parameter int IW = 10,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic [IW-1:0] StartAddr,
    input  logic          Stall,
    input  logic          BranchEn,
    input  logic          BranchRel,
    input  logic [IW-1:0] Target,
    input  logic          HaltReq,
    output logic [IW-1:0] InstAddress,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] CycleCount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t state;

    // PC plus a sign-extended offset; the carry out of bit IW-1 is dropped,
    // which gives the required modulo-2**IW wrap.
    function automatic logic [IW-1:0] rel_target(
        input logic        [IW-1:0] pc,
        input logic signed [IW-1:0] off
    );
        logic signed [IW:0] off_ext;
        logic signed [IW:0] sum;
        off_ext = {off[IW-1], off};
        sum     = $signed({1'b0, pc}) + off_ext;
        return sum[IW-1:0];
    endfunction

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state       <= ST_IDLE;
            InstAddress <= '0;
            Running     <= 1'b0;
            Done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    Done <= 1'b0;
                    // HaltReq has no meaning here; Start alone decides.
                    if (Start) begin
                        InstAddress <= StartAddr;
                        state       <= ST_RUN;
                        Running     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (HaltReq) begin
                        state   <= ST_HALT;
                        Running <= 1'b0;
                        Done    <= 1'b1;
                    end else if (Stall) begin
                        InstAddress <= InstAddress;
                    end else if (BranchEn) begin
                        if (BranchRel)
                            InstAddress <= rel_target(InstAddress, $signed(Target));
                        else
                            InstAddress <= Target;
                    end else begin
                        InstAddress <= InstAddress + IW'(1);
                    end
                end
                ST_HALT: begin
                    Done    <= 1'b0;
                    Running <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    Running <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_CYCLE_COUNT_EN
    logic [CW-1:0] cycle_cnt;

    // Cleared on the IDLE->RUN edge, counts every RUN edge (stalls too),
    // saturates, and holds through HALT and IDLE until the next run.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cycle_cnt <= '0;
        end else if (state == ST_IDLE && Start) begin
            cycle_cnt <= '0;
        end else if (state == ST_RUN && cycle_cnt != {CW{1'b1}}) begin
            cycle_cnt <= cycle_cnt + CW'(1);
        end
    end

    assign CycleCount = cycle_cnt;
`else
    assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam int IW = 10;
    localparam int CW = 16;

`ifdef FETCH_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          Start;
    logic [IW-1:0] StartAddr;
    logic          Stall;
    logic          BranchEn;
    logic          BranchRel;
    logic [IW-1:0] Target;
    logic          HaltReq;
    logic [IW-1:0] InstAddress;
    logic          Running;
    logic          Done;
    logic [CW-1:0] CycleCount;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_ctrl #(.IW(IW), .CW(CW)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .StartAddr  (StartAddr),
        .Stall      (Stall),
        .BranchEn   (BranchEn),
        .BranchRel  (BranchRel),
        .Target     (Target),
        .HaltReq    (HaltReq),
        .InstAddress(InstAddress),
        .Running    (Running),
        .Done       (Done),
        .CycleCount (CycleCount)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    task automatic check_state(input string tag, input int pc, input bit run,
                               input bit done, input int cnt);
        check({tag, ".pc"},   32'(InstAddress), 32'(pc));
        check({tag, ".run"},  32'(Running), 32'(run));
        check({tag, ".done"}, 32'(Done), 32'(done));
        check({tag, ".cnt"},  32'(CycleCount), exp_cnt(cnt));
    endtask

    task automatic branch(input bit rel, input logic [IW-1:0] tgt);
        BranchEn = 1'b1; BranchRel = rel; Target = tgt;
        tick();
        BranchEn = 1'b0; BranchRel = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0; Start = 1'b0; StartAddr = '0; Stall = 1'b0;
        BranchEn = 1'b0; BranchRel = 1'b0; Target = '0; HaltReq = 1'b0;
        @(negedge Clk);
        // Reset with Start asserted must still land in IDLE.
        Start = 1'b1; StartAddr = 10'd77;
        tick();
        check_state("reset", 0, 0, 0, 0);
        Start = 1'b0;
        Reset_n = 1'b1;
        tick();
        check_state("idle_after_reset", 0, 0, 0, 0);

        // Run from 5, sequential fetch.
        Start = 1'b1; StartAddr = 10'd5;
        tick();
        Start = 1'b0;
        check_state("start5", 5, 1, 0, 0);
        tick(); check_state("seq6", 6, 1, 0, 1);
        tick(); check_state("seq7", 7, 1, 0, 2);
        tick(); check_state("seq8", 8, 1, 0, 3);

        // Branches.
        branch(1'b0, 10'd20);    check("abs20", 32'(InstAddress), 32'd20);
        branch(1'b1, 10'h3FD);   check("rel_m3", 32'(InstAddress), 32'd17);
        branch(1'b0, 10'd100);   check("abs100", 32'(InstAddress), 32'd100);
        branch(1'b0, 10'd1023);  check("abs1023", 32'(InstAddress), 32'd1023);
        tick();                  check("wrap0", 32'(InstAddress), 32'd0);
        branch(1'b0, 10'd3);     check("abs3", 32'(InstAddress), 32'd3);
        branch(1'b1, 10'h3FB);   check("rel_m5", 32'(InstAddress), 32'd1022);
        branch(1'b0, 10'd40);    check_state("abs40", 40, 1, 0, 11);

        // Stall beats branch.
        Stall = 1'b1; BranchEn = 1'b1; BranchRel = 1'b0; Target = 10'd300;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state($sformatf("stall%0d", i), 40, 1, 0, 12 + i);
        end
        // Halt beats branch.
        Stall = 1'b0; HaltReq = 1'b1;
        tick();
        HaltReq = 1'b0; BranchEn = 1'b0;
        check_state("halt", 40, 0, 1, 15);
        // Start during HALT is ignored.
        Start = 1'b1; StartAddr = 10'd200;
        tick();
        check_state("idle_after_halt", 40, 0, 0, 15);
        // Start in the IDLE cycle after Done is accepted.
        tick();
        check_state("restart200", 200, 1, 0, 0);
        // Start during RUN is ignored.
        StartAddr = 10'd500;
        tick();
        Start = 1'b0;
        check_state("start_in_run", 201, 1, 0, 1);
        branch(1'b0, 10'd57);
        check_state("abs57", 57, 1, 0, 2);
        // Reset mid-run aborts without Done.
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        check_state("reset_midrun", 0, 0, 0, 0);
        tick();
        check_state("idle_stays", 0, 0, 0, 0);

        // Start and HaltReq together in IDLE: Start wins.
        Start = 1'b1; HaltReq = 1'b1; StartAddr = 10'd9;
        tick();
        Start = 1'b0; HaltReq = 1'b0;
        check_state("start_vs_halt", 9, 1, 0, 0);
        tick();
        check_state("seq10", 10, 1, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
